// File: rtl/bimux_nx1_reg.sv
// bimux_nx1_reg: registered N-to-1 bidirectional lane selector.
// Gathers one WIDTH-bit lane of a CHANNELS-wide bus onto rsp_data, or
// scatters req_data onto a selected lane. Scattered values are held in
// per-lane registers. A one-cycle turnaround with every driver released
// is inserted whenever the transfer direction changes. Tristate pads
// outside this block consume lane_out/lane_oe.
module bimux_nx1_reg #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_dir,
    input  logic [SEL_W-1:0]          req_sel,
    input  logic [WIDTH-1:0]          req_data,
    input  logic [CHANNELS*WIDTH-1:0] lane_in,
    output logic [CHANNELS*WIDTH-1:0] lane_out,
    output logic [CHANNELS-1:0]       lane_oe,
    output logic                      dir_q,
    output logic                      rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_err
);

    // Transfer sequencing: wait for a request, optionally turn the bus
    // around, then spend exactly one cycle moving data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    // Number of real lanes, widened by one bit so that a select equal to
    // 2**SEL_W - 1 can still be compared against CHANNELS == 2**SEL_W.
    localparam logic [SEL_W:0] LANE_LIMIT = (SEL_W+1)'(CHANNELS);

    state_t              state;
    state_t              state_nxt;

    // Request fields captured in the accept cycle; later req_* activity
    // is ignored until the block returns to IDLE.
    logic                cap_dir;
    logic [SEL_W-1:0]    cap_sel;
    logic [WIDTH-1:0]    cap_data;

    // Sticky set of lanes written since the current scatter phase began.
    logic [CHANNELS-1:0] mask;

    logic                accept;
    logic                sel_ok;
    logic                in_xfer;
    logic                in_turn;
    logic [WIDTH-1:0]    gather_val;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_xfer   = (state == XFER);
    assign in_turn   = (state == TURN);
    assign sel_ok    = ({1'b0, cap_sel} < LANE_LIMIT);

    // Next-state decision: a direction change detours through TURN.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the case leaves it unassigned (which infers a latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (req_dir != dir_q) ? TURN : XFER;
                end
            end
            TURN:    state_nxt = XFER;
            XFER:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request in the accept cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_dir  <= 1'b0;
            cap_sel  <= '0;
            cap_data <= '0;
        end else if (accept) begin
            cap_dir  <= req_dir;
            cap_sel  <= req_sel;
            cap_data <= req_data;
        end
    end

    // Committed direction changes only at the end of the turnaround cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (in_turn) begin
            dir_q <= cap_dir;
        end
    end

    // Gather mux: pick the selected lane from the live lane bus. It is
    // consumed only in XFER, so lane_in is effectively sampled then.
    always_comb begin
        gather_val = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cap_sel == SEL_W'(k)) begin
                gather_val = lane_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Per-lane held drive values and the sticky drive mask. The mask is
    // wiped in TURN so a new scatter phase starts with nothing driven,
    // while the held values survive direction changes.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: lane_out is a small flop bank rather than a RAM, so it is
        // reset along with everything else; pads see known zeros.
        if (!rst_n) begin
            lane_out <= '0;
            mask     <= '0;
        end else if (in_turn) begin
            mask <= '0;
        end else if (in_xfer && cap_dir && sel_ok) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (cap_sel == SEL_W'(k)) begin
                    lane_out[k*WIDTH +: WIDTH] <= cap_data;
                    mask[k]                    <= 1'b1;
                end
            end
        end
    end

    // Response: one-cycle valid pulse at XFER exit; data and error hold
    // until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= in_xfer;
            if (in_xfer) begin
                if (!sel_ok) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else if (cap_dir) begin
                    rsp_data <= cap_data;
                    rsp_err  <= 1'b0;
                end else begin
                    rsp_data <= gather_val;
                    rsp_err  <= 1'b0;
                end
            end
        end
    end

    // Drivers are enabled only while committed to scatter and never
    // during the turnaround cycle.
    assign lane_oe = (dir_q && !in_turn) ? mask : '0;

endmodule

// File: doc/bimux_nx1_reg.md
# bimux_nx1_reg

Parametrised, registered successor to the 8x1 bidirectional lane selector in the subleq datapath. It gathers one lane of a CHANNELS-wide bus onto a single WIDTH-bit result, or scatters a WIDTH-bit value onto a selected lane, under a valid/ready request handshake. It holds scattered values in per-lane registers and inserts a one-cycle bus turnaround with all drivers off whenever direction changes. Top-level tristate pads consume lane_out/lane_oe; no inout ports exist inside the block.

## Interface
Parameters:
- WIDTH, 1, bits per lane
- CHANNELS, 8, lane count (2..256)
- SEL_W, 3, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_dir  in  1  0 = gather (lane -> rsp), 1 = scatter (req_data -> lane)
- req_sel  in  SEL_W  lane index
- req_data  in  WIDTH  scatter data (ignored for gather)
- lane_in  in  CHANNELS*WIDTH  lane bus sampled value; lane k = bits [k*WIDTH +: WIDTH]
- lane_out  out  CHANNELS*WIDTH  per-lane held drive values
- lane_oe  out  CHANNELS  per-lane drive enable
- dir_q  out  1  current committed direction
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  WIDTH  gathered value, or echoed scatter data
- rsp_err  out  1  qualifies rsp_valid: req_sel >= CHANNELS

## Operation
- States: IDLE, TURN, XFER. req_ready = (state == IDLE), combinational.
- IDLE: on req_valid && req_ready capture dir/sel/data. If captured dir != dir_q -> TURN, else -> XFER.
- TURN (1 cycle): lane_oe forced to all-0; dir_q <= captured dir; scatter enable mask cleared. -> XFER.
- XFER (1 cycle), -> IDLE, registering at exit edge:
  - gather, sel valid: rsp_data <= lane_in lane sel (sampled in XFER); rsp_err <= 0.
  - scatter, sel valid: lane_out[sel] <= data; mask[sel] <= 1; rsp_data <= data; rsp_err <= 0.
  - sel >= CHANNELS: no lane_out/mask change; rsp_data <= 0; rsp_err <= 1.
  - rsp_valid <= 1 for exactly one cycle.
- lane_oe = mask when dir_q = 1 and state != TURN; all-0 when dir_q = 0 or in TURN.
- Mask is sticky: every lane written since entering scatter stays driven; cleared only in TURN or by reset.
- lane_out values persist across direction changes; only reset clears them.
- No backpressure on response; rsp_* hold value until next XFER exit (rsp_valid low otherwise).
- req_* are sampled only in the accept cycle; changes during TURN/XFER are ignored.

## Timing
- Reset (rst_n low, async): state IDLE, dir_q 0, lane_out 0, mask 0, lane_oe 0, rsp_valid 0, rsp_data 0, rsp_err 0. req_ready reads 1, but no request is accepted while rst_n is low.
- Reset asserted mid-TURN/XFER aborts: no rsp_valid and no lane write. Outputs take reset values immediately.
- Same-direction latency: accept at edge T; rsp_valid high in the cycle after edge T+1. New lane_out/lane_oe are visible after T+1.
- Direction change adds 1 cycle: rsp_valid after edge T+2. lane_oe is 0 from edge T+1 to T+2.
- Throughput: 1 request per 2 cycles (same dir) or per 3 cycles (dir change). req_ready is low the cycle after accept.
- Gather sample point: lane_in during the XFER cycle, not the accept cycle.

## Test plan
- Reset then gather sel=5, lane_in lane5=1, others 0 (WIDTH=1) -> rsp_valid 2 cycles after accept, rsp_data=1, rsp_err=0, lane_oe=0, dir_q=0.
- From gather, scatter sel=2 data=1 -> TURN cycle with lane_oe=00000000, dir_q=1. rsp_valid 3 cycles after accept. lane_out bit2=1, lane_oe=00000100.
- Scatter sel=7 data=0, then sel=0 data=1 (dir unchanged) -> each 2-cycle latency. Final lane_oe=10000101, lane_out=00000101.
- Scatter then gather sel=2 -> TURN drops lane_oe to 0 and it stays 0. lane_out still 00000101. Gather returns the sampled lane_in bit.
- CHANNELS=5, SEL_W=3, sel=6 in both dirs -> rsp_err=1, rsp_data=0, lane_out/lane_oe unchanged.
- Assert rst_n low during XFER of a scatter -> no rsp_valid, lane_out=0, lane_oe=0, dir_q=0. The first request after release is accepted normally.
